apb_mem_slave: RTL and testbench

- APB responder: the slave end of the APB bus, serving transfers issued by the APB master.
- Decodes its select code and inserts the number of wait states requested on wait_cycles.
- Converts each accepted transfer into a single-cycle strobe on the memory-side bus and returns read data and ready to the master.
- Sits between the APB bus and one 256x8 memory instance.

---
 rtl/apb_mem_slave.sv | 184 ++++++++++++++++++
 tb/tb_apb_mem_slave.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// -----------------------------------------------------------------------------
// apb_mem_slave
//   APB responder in front of one 256x8 memory. The slave decodes its select
//   code and counts down the wait states requested for the transfer. It then
//   issues a single-cycle chip-enable plus a read or write strobe to the
//   memory, and returns ready (and read data) to the master.
//
// Ports
//   clk          bus clock, all state updates on the rising edge
//   reset        asynchronous active-low reset
//   sel          slave select code (0 = no slave selected)
//   enable       0 = setup phase, 1 = access phase
//   write        1 = write, 0 = read
//   addr, wdata  transfer address / write data
//   wait_cycles  wait states for this transfer, sampled in the setup phase
//   ready        one-cycle transfer-complete strobe
//   rdata        read data, only updated by completed reads
//   mem_ce       memory chip enable (one pulse per issued access)
//   mem_wren     memory write strobe
//   mem_rden     memory read strobe
//   mem_addr     memory address
//   mem_wdata    memory write data
//   mem_rdata    memory read data, valid one cycle after mem_rden
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module apb_mem_slave #(
  parameter logic [1:0] SEL_ID     = 2'd1,
  parameter int         MEM_RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic       enable,
  input  logic       write,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] wait_cycles,
  output logic       ready,
  output logic [7:0] rdata,
  output logic       mem_ce,
  output logic       mem_wren,
  output logic       mem_rden,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  // Only a one-cycle memory read latency is handled: the read strobe is
  // issued on entry to MEM and the data is captured on the following edge.
  localparam bit LAT_OK = (MEM_RD_LAT == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    MEM  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       wr_reg, wr_next;

  logic       ready_next;
  logic [7:0] rdata_next;
  logic       ce_next;
  logic       wren_next;
  logic       rden_next;
  logic [7:0] addr_next;
  logic [7:0] wdata_next;

  logic selected;
  logic setup_phase;

  // Any other nonzero code counts as a deselect.
  assign selected    = (sel == SEL_ID);
  assign setup_phase = selected && !enable;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      wr_reg    <= 1'b0;
      ready     <= 1'b0;
      rdata     <= '0;
      mem_ce    <= 1'b0;
      mem_wren  <= 1'b0;
      mem_rden  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wr_reg    <= wr_next;
      ready     <= ready_next;
      rdata     <= rdata_next;
      mem_ce    <= ce_next;
      mem_wren  <= wren_next;
      mem_rden  <= rden_next;
      mem_addr  <= addr_next;
      mem_wdata <= wdata_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wr_next    = wr_reg;
    addr_next  = mem_addr;
    wdata_next = mem_wdata;
    rdata_next = rdata;
    // Strobes and ready are pulses: they fall unless explicitly raised.
    ready_next = 1'b0;
    ce_next    = 1'b0;
    wren_next  = 1'b0;
    rden_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        // An access phase with no preceding setup phase is ignored.
        if (setup_phase) begin
          addr_next  = addr;
          wdata_next = wdata;
          wr_next    = write;
          cnt_next   = wait_cycles;
          state_next = WAIT;
        end
      end

      WAIT: begin
        if (!selected || !enable) begin
          state_next = IDLE;
        end else if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
        end else begin
          ce_next    = 1'b1;
          wren_next  = wr_reg;
          rden_next  = !wr_reg;
          state_next = MEM;
        end
      end

      MEM: begin
        // An abort here cannot recall a write strobe already issued; it
        // only suppresses ready and the read-data update.
        if (!selected || !enable) begin
          state_next = IDLE;
        end else begin
          if (!wr_reg && LAT_OK) begin
            rdata_next = mem_rdata;
          end
          ready_next = 1'b1;
          state_next = DONE;
        end
      end

      DONE: begin
        // The master may already present its next setup phase while ready
        // is high; accept it straight away so back-to-back transfers do
        // not lose a cycle in IDLE.
        if (setup_phase) begin
          addr_next  = addr;
          wdata_next = wdata;
          wr_next    = write;
          cnt_next   = wait_cycles;
          state_next = WAIT;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_mem_slave
//   Directed-vector bench for apb_mem_slave. The driver pushes the expected
//   memory strobe and ready response of each transfer into two queues; a
//   monitor pops and compares whenever mem_ce or ready is seen high.
//   The memory behind the slave is a 256x8 array preloaded with addr ^ 8'h5A.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_apb_mem_slave;

  localparam logic [1:0] SEL_ID = 2'd1;

  logic       clk;
  logic       reset;
  logic [1:0] sel;
  logic       enable;
  logic       write;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] wait_cycles;
  logic       ready;
  logic [7:0] rdata;
  logic       mem_ce;
  logic       mem_wren;
  logic       mem_rden;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  apb_mem_slave #(
    .SEL_ID     (SEL_ID),
    .MEM_RD_LAT (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sel         (sel),
    .enable      (enable),
    .write       (write),
    .addr        (addr),
    .wdata       (wdata),
    .wait_cycles (wait_cycles),
    .ready       (ready),
    .rdata       (rdata),
    .mem_ce      (mem_ce),
    .mem_wren    (mem_wren),
    .mem_rden    (mem_rden),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: write on the edge, read data presented for the cycle in
  // which the read strobe is high, so it is sampled one edge after the strobe.
  logic [7:0] tb_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'(i) ^ 8'h5A;
  end
  always @(posedge clk) begin
    if (mem_ce && mem_wren) tb_mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = tb_mem[mem_addr];

  // Rising-edge counter; at a falling edge, cyc is the index of the last edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         at_edge;
  } exp_t;

  exp_t strobe_q[$];
  exp_t ready_q[$];

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (!mem_ce && (mem_wren || mem_rden)) begin
        errors++;
        $display("FAIL stray_strobe: wren=%0b rden=%0b with mem_ce=0 at edge %0d",
                 mem_wren, mem_rden, cyc);
      end
      if (mem_ce) begin
        checks++;
        if (strobe_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: wren=%0b rden=%0b addr=%h at edge %0d, none expected",
                   mem_wren, mem_rden, mem_addr, cyc);
        end else begin
          exp_t e;
          e = strobe_q.pop_front();
          if (mem_wren !== e.wr || mem_rden !== !e.wr || mem_addr !== e.addr ||
              (e.wr && mem_wdata !== e.data) || cyc != e.at_edge) begin
            errors++;
            $display("FAIL strobe: got wren=%0b rden=%0b addr=%h wdata=%h edge=%0d, want wr=%0b addr=%h wdata=%h edge=%0d",
                     mem_wren, mem_rden, mem_addr, mem_wdata, cyc, e.wr, e.addr, e.data, e.at_edge);
          end else begin
            $display("strobe ok: %s addr=%h wdata=%h edge=%0d",
                     e.wr ? "WR" : "RD", mem_addr, mem_wdata, cyc);
          end
        end
      end
      if (ready) begin
        checks++;
        if (ready_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready: rdata=%h at edge %0d, none expected", rdata, cyc + 1);
        end else begin
          exp_t e;
          e = ready_q.pop_front();
          if (rdata !== e.data || (cyc + 1) != e.at_edge) begin
            errors++;
            $display("FAIL ready: got rdata=%h sampled at edge %0d, want rdata=%h at edge %0d",
                     rdata, cyc + 1, e.data, e.at_edge);
          end else begin
            $display("ready ok: %s addr=%h rdata=%h edge=%0d",
                     e.wr ? "WR" : "RD", e.addr, rdata, cyc + 1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks. Each one starts and ends at a falling edge.
  // ---------------------------------------------------------------------------
  task automatic idle();
    sel    = 2'd0;
    enable = 1'b0;
    @(negedge clk);
  endtask

  // Complete transfer; returns in the DONE cycle (ready high) so the caller
  // can issue a back-to-back setup phase immediately.
  task automatic xfer_full(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] wc, input logic [7:0] exp_rd);
    int   setup_edge;
    int   n;
    exp_t e;
    sel         = SEL_ID;
    enable      = 1'b0;
    write       = w;
    addr        = a;
    wdata       = d;
    wait_cycles = wc;
    setup_edge  = cyc + 1;
    e.wr = w; e.addr = a; e.data = d;      e.at_edge = setup_edge + int'(wc) + 1;
    strobe_q.push_back(e);
    e.wr = w; e.addr = a; e.data = exp_rd; e.at_edge = setup_edge + int'(wc) + 3;
    ready_q.push_back(e);
    @(negedge clk);
    enable = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < int'(wc) + 10) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: addr=%h ready=%b after %0d cycles, want 1", a, ready, n);
    end
  endtask

  // Transfer cut short after ncyc access-phase edges (or never answered).
  task automatic xfer_cut(input logic [1:0] s, input logic w, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] wc, input int ncyc,
                          input bit exp_strobe);
    exp_t e;
    sel         = s;
    enable      = 1'b0;
    write       = w;
    addr        = a;
    wdata       = d;
    wait_cycles = wc;
    if (exp_strobe) begin
      e.wr = w; e.addr = a; e.data = d; e.at_edge = cyc + 1 + int'(wc) + 1;
      strobe_q.push_back(e);
    end
    @(negedge clk);
    enable = 1'b1;
    repeat (ncyc) @(negedge clk);
    idle();
  endtask

  task automatic check_outputs_zero(input string name);
    logic [27:0] v;
    v = {ready, rdata, mem_ce, mem_wren, mem_rden, mem_addr, mem_wdata};
    checks++;
    if (v !== 28'd0) begin
      errors++;
      $display("FAIL %s: outputs {ready,rdata,ce,wren,rden,addr,wdata}=%h, want 0", name, v);
    end else begin
      $display("%s ok: all outputs 0", name);
    end
  endtask

  task automatic check_mem(input logic [7:0] a, input logic [7:0] want);
    checks++;
    if (tb_mem[a] !== want) begin
      errors++;
      $display("FAIL mem_content: mem[%h]=%h, want %h", a, tb_mem[a], want);
    end else begin
      $display("mem_content ok: mem[%h]=%h", a, want);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset       = 1'b1;
    sel         = 2'd0;
    enable      = 1'b0;
    write       = 1'b0;
    addr        = '0;
    wdata       = '0;
    wait_cycles = '0;
    #1 reset = 1'b0;
    #2 check_outputs_zero("reset_initial");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Write then read back, zero wait states (rdata still 0 during the write).
    xfer_full(1'b1, 8'h3C, 8'hA5, 8'd0, 8'h00);
    idle();
    xfer_full(1'b0, 8'h3C, 8'h00, 8'd0, 8'hA5);
    idle();

    // Four wait states.
    xfer_full(1'b0, 8'h07, 8'h00, 8'd4, 8'h5D);
    idle();

    // Another slave's select code: nothing may happen.
    xfer_cut(2'd2, 1'b1, 8'h10, 8'hFF, 8'd0, 6, 1'b0);
    check_mem(8'h10, 8'h4A);
    xfer_full(1'b0, 8'h10, 8'h00, 8'd0, 8'h4A);
    idle();

    // Abort in WAIT: no strobe, old data survives.
    xfer_cut(SEL_ID, 1'b1, 8'h3C, 8'h77, 8'd5, 2, 1'b0);
    check_mem(8'h3C, 8'hA5);
    xfer_full(1'b0, 8'h3C, 8'h00, 8'd0, 8'hA5);
    idle();

    // Back-to-back reads, each setup issued in the previous DONE cycle.
    xfer_full(1'b0, 8'h00, 8'h00, 8'd0, 8'h5A);
    xfer_full(1'b0, 8'h01, 8'h00, 8'd0, 8'h5B);
    xfer_full(1'b0, 8'h02, 8'h00, 8'd0, 8'h58);
    idle();

    // Abort in MEM: the issued write lands, but no ready.
    xfer_cut(SEL_ID, 1'b1, 8'h20, 8'hC3, 8'd0, 1, 1'b1);
    check_mem(8'h20, 8'hC3);
    xfer_full(1'b0, 8'h20, 8'h00, 8'd0, 8'hC3);
    idle();

    // Maximum wait count, then a write that must leave rdata alone.
    xfer_full(1'b0, 8'h3C, 8'h00, 8'd255, 8'hA5);
    idle();
    xfer_full(1'b1, 8'h40, 8'h11, 8'd2, 8'hA5);
    idle();
    check_mem(8'h40, 8'h11);

    // Reset mid-WAIT: outputs clear without a clock edge, and a held access
    // phase after release is not mistaken for a new transfer.
    sel         = SEL_ID;
    enable      = 1'b0;
    write       = 1'b1;
    addr        = 8'h55;
    wdata       = 8'h66;
    wait_cycles = 8'd10;
    @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_outputs_zero("reset_async");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    idle();
    check_mem(8'h55, 8'h0F);
    xfer_full(1'b0, 8'h3C, 8'h00, 8'd1, 8'hA5);
    idle();
    repeat (3) @(negedge clk);

    checks++;
    if (strobe_q.size() != 0 || ready_q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d strobes and %0d readies never seen, want 0 and 0",
               strobe_q.size(), ready_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
